// File: rtl/regwr_arbiter.sv
// -----------------------------------------------------------------------------
// regwr_arbiter
//
// Purpose:
//   Shares the register file's single write port between the pipeline
//   writeback stage (high priority) and the multi-cycle multiply/divide unit.
//   A starvation counter guarantees the mul/div result is written within
//   STARVE_LIMIT cycles of its first refusal: once the limit is reached the
//   arbiter spends one cycle in FORCE_MD, stalling the pipeline and granting
//   mul/div unconditionally. A busy scoreboard marks destination registers
//   whose mul/div result has not yet been transferred, for hazard detection.
//
// Parameters:
//   WIDTH        data width of busW / wb_data / md_data
//   STARVE_LIMIT cycles md may be refused before a forced grant (1..15)
//
// Ports:
//   clk          in   clock, rising-edge active
//   rst_n        in   asynchronous active-low reset
//   wb_valid     in   writeback write request (high priority)
//   wb_rw        in   writeback destination register
//   wb_data      in   writeback data
//   md_issue     in   mul/div instruction issued this cycle
//   md_issue_rw  in   destination of the issued mul/div
//   md_valid     in   mul/div result available
//   md_rw        in   mul/div result destination
//   md_data      in   mul/div result data
//   md_ready     out  mul/div result accepted when md_valid && md_ready
//   stall_req    out  pipeline must freeze (writeback holds its request)
//   RegWr        out  register file write enable (registered)
//   Rw           out  register file write address (registered)
//   busW         out  register file write data (registered)
//   busy_mask    out  bit i set: register i awaits a mul/div result
// -----------------------------------------------------------------------------
module regwr_arbiter #(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rw,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             md_issue,
   input  logic [4:0]       md_issue_rw,
   input  logic             md_valid,
   input  logic [4:0]       md_rw,
   input  logic [WIDTH-1:0] md_data,
   output logic             md_ready,
   output logic             stall_req,
   output logic             RegWr,
   output logic [4:0]       Rw,
   output logic [WIDTH-1:0] busW,
   output logic [31:0]      busy_mask
);

   typedef enum logic {
      PRI_WB   = 1'b0,
      FORCE_MD = 1'b1
   } state_t;

   // Refusal count at which the next refusal forces a grant.
   localparam logic [3:0] LP_WAIT_LAST = 4'(STARVE_LIMIT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_wait_cnt;
   logic [3:0]         w_wait_cnt_nxt;

   logic               w_grant_wb;
   logic               w_grant_md;
   logic               w_md_xfer;

   logic               w_wr_en;
   logic [4:0]         w_wr_rw;
   logic [WIDTH-1:0]   w_wr_data;

   logic               r_regwr;
   logic [4:0]         r_rw;
   logic [WIDTH-1:0]   r_busw;

   logic [31:0]        r_busy;
   logic [31:0]        w_busy_set;
   logic [31:0]        w_busy_clr;
   logic [31:0]        w_busy_nxt;

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PRI_WB;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state, grants and handshake outputs
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      md_ready       = 1'b0;
      stall_req      = 1'b0;
      w_grant_wb     = 1'b0;
      w_grant_md     = 1'b0;

      case (r_state)
         PRI_WB: begin
            md_ready   = !wb_valid;
            w_grant_wb = wb_valid;
            w_grant_md = !wb_valid && md_valid;
            if (md_valid && wb_valid) begin
               // md refused this cycle: count it, and escalate once the
               // refusal budget is used up.
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
               if (r_wait_cnt == LP_WAIT_LAST) begin
                  w_state_nxt = FORCE_MD;
               end
            end else begin
               // Either md transferred or nothing is waiting.
               w_wait_cnt_nxt = 4'd0;
            end
         end

         FORCE_MD: begin
            md_ready       = 1'b1;
            stall_req      = 1'b1;
            w_grant_md     = md_valid;
            // Always a single cycle: either the forced transfer happens, or
            // the result was withdrawn and there is nothing left to force.
            w_wait_cnt_nxt = 4'd0;
            w_state_nxt    = PRI_WB;
         end

         default: begin
            w_state_nxt    = PRI_WB;
            w_wait_cnt_nxt = 4'd0;
         end
      endcase
   end

   assign w_md_xfer = md_valid && md_ready;

   // --------------------------------------------------------------------------
   // Write-command selection. A grant to register 0 still completes its
   // handshake, but produces no write and leaves Rw/busW untouched.
   // --------------------------------------------------------------------------
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_rw   = wb_rw;
      w_wr_data = wb_data;
      if (w_grant_wb) begin
         w_wr_en   = (wb_rw != 5'd0);
         w_wr_rw   = wb_rw;
         w_wr_data = wb_data;
      end else if (w_grant_md) begin
         w_wr_en   = (md_rw != 5'd0);
         w_wr_rw   = md_rw;
         w_wr_data = md_data;
      end
   end

   // --------------------------------------------------------------------------
   // Busy scoreboard next value. Set is applied after clear so a same-cycle
   // issue and transfer to one register leaves it busy; bit 0 never sets.
   // --------------------------------------------------------------------------
   always_comb begin
      w_busy_set = 32'd0;
      w_busy_clr = 32'd0;
      if (md_issue) begin
         w_busy_set = 32'd1 << md_issue_rw;
      end
      if (w_md_xfer) begin
         w_busy_clr = 32'd1 << md_rw;
      end
      w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
   end

   // --------------------------------------------------------------------------
   // Registered write port and scoreboard
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regwr <= 1'b0;
         r_rw    <= 5'd0;
         r_busw  <= '0;
         r_busy  <= 32'd0;
      end else begin
         r_regwr <= w_wr_en;
         if (w_wr_en) begin
            r_rw   <= w_wr_rw;
            r_busw <= w_wr_data;
         end
         r_busy  <= w_busy_nxt;
      end
   end

   assign RegWr     = r_regwr;
   assign Rw        = r_rw;
   assign busW      = r_busw;
   assign busy_mask = r_busy;

endmodule

// File: tb/tb_regwr_arbiter.sv
module tb_regwr_arbiter;
   localparam int WIDTH        = 32;
   localparam int STARVE_LIMIT = 4;

   logic             clk;
   logic             rst_n;
   logic             wb_valid;
   logic [4:0]       wb_rw;
   logic [WIDTH-1:0] wb_data;
   logic             md_issue;
   logic [4:0]       md_issue_rw;
   logic             md_valid;
   logic [4:0]       md_rw;
   logic [WIDTH-1:0] md_data;
   logic             md_ready;
   logic             stall_req;
   logic             RegWr;
   logic [4:0]       Rw;
   logic [WIDTH-1:0] busW;
   logic [31:0]      busy_mask;

   int nchecks = 0;
   int nerr    = 0;

   // Reference model state (spec-level: count of consecutive refusals,
   // expected write-port contents, scoreboard bit array).
   int               m_refused;
   bit               m_busy [32];
   logic             m_regwr;
   logic [4:0]       m_rw;
   logic [WIDTH-1:0] m_busw;
   bit               m_last_md_g;

   regwr_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_data(wb_data),
      .md_issue(md_issue), .md_issue_rw(md_issue_rw),
      .md_valid(md_valid), .md_rw(md_rw), .md_data(md_data),
      .md_ready(md_ready), .stall_req(stall_req),
      .RegWr(RegWr), .Rw(Rw), .busW(busW), .busy_mask(busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ir,
                        input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
      wb_valid = wv; wb_rw = wr; wb_data = wd;
      md_issue = iv; md_issue_rw = ir;
      md_valid = mv; md_rw = mr; md_data = mdd;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      for (int i = 0; i < 32; i++) m[i] = m_busy[i];
      return m;
   endfunction

   task automatic model_reset();
      m_refused = 0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_regwr = 1'b0; m_rw = 5'd0; m_busw = '0; m_last_md_g = 1'b0;
   endtask

   // md is forced once it has been refused STARVE_LIMIT cycles in a row.
   task automatic model_eval(output bit rdy, output bit stl);
      stl = (m_refused >= STARVE_LIMIT);
      rdy = stl || !wb_valid;
   endtask

   task automatic model_commit(input bit rdy, input bit stl);
      bit wb_g, md_g;
      wb_g = wb_valid && !stl;
      md_g = md_valid && rdy;
      if (wb_g) begin
         m_regwr = (wb_rw != 0);
         if (wb_rw != 0) begin m_rw = wb_rw; m_busw = wb_data; end
      end else if (md_g) begin
         m_regwr = (md_rw != 0);
         if (md_rw != 0) begin m_rw = md_rw; m_busw = md_data; end
      end else begin
         m_regwr = 1'b0;
      end
      if (md_g) m_busy[md_rw] = 1'b0;
      if (md_issue && md_issue_rw != 0) m_busy[md_issue_rw] = 1'b1;
      m_refused   = (md_valid && !rdy) ? m_refused + 1 : 0;
      m_last_md_g = md_g;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nchecks++; if (RegWr !== 1'b0) begin nerr++; $display("FAIL reset_regwr: got %0h required 0", RegWr); end
      nchecks++; if (Rw !== 5'd0) begin nerr++; $display("FAIL reset_rw: got %0h required 0", Rw); end
      nchecks++; if (busW !== 32'd0) begin nerr++; $display("FAIL reset_busw: got %0h required 0", busW); end
      nchecks++; if (busy_mask !== 32'd0) begin nerr++; $display("FAIL reset_busy: got %0h required 0", busy_mask); end
      nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %0h required 0", stall_req); end
      nchecks++; if (md_ready !== 1'b1) begin nerr++; $display("FAIL reset_mdready: got %0h required 1", md_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_wb_only();
      @(negedge clk);
      drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      #1;
      nchecks++; if (md_ready !== 1'b0) begin nerr++; $display("FAIL wb_only_mdready: got %0h required 0", md_ready); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1) begin nerr++; $display("FAIL wb_only_regwr: got %0h required 1", RegWr); end
      nchecks++; if (Rw !== 5'd5) begin nerr++; $display("FAIL wb_only_rw: got %0h required 5", Rw); end
      nchecks++; if (busW !== 32'h1234) begin nerr++; $display("FAIL wb_only_busw: got %0h required 1234", busW); end
      @(negedge clk); idle();
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b0) begin nerr++; $display("FAIL wb_only_idle_regwr: got %0h required 0", RegWr); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      drive(1'b1, 5'd3, 32'h1111_0003, 1'b0, 5'd0, 1'b1, 5'd7, 32'h2222_0007);
      #1;
      nchecks++; if (md_ready !== 1'b0) begin nerr++; $display("FAIL simul_mdready_n: got %0h required 0", md_ready); end
      nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL simul_stall_n: got %0h required 0", stall_req); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd3 || busW !== 32'h1111_0003) begin nerr++; $display("FAIL simul_wb_write: got %0h/%0h/%0h required 1/3/11110003", RegWr, Rw, busW); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h2222_0007);
      #1;
      nchecks++; if (md_ready !== 1'b1) begin nerr++; $display("FAIL simul_mdready_n1: got %0h required 1", md_ready); end
      nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL simul_stall_n1: got %0h required 0", stall_req); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd7 || busW !== 32'h2222_0007) begin nerr++; $display("FAIL simul_md_write: got %0h/%0h/%0h required 1/7/22220007", RegWr, Rw, busW); end
      @(negedge clk); idle();
   endtask

   task automatic test_starvation();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 5'd4, 32'hAAAA, 1'b0, 5'd0, 1'b1, 5'd9, 32'hBEEF);
         #1;
         nchecks++; if (md_ready !== 1'b0 || stall_req !== 1'b0) begin nerr++; $display("FAIL starve_refused_c%0d: got ready=%0h stall=%0h required 0/0", c, md_ready, stall_req); end
         @(posedge clk);
      end
      @(negedge clk); #1;
      nchecks++; if (stall_req !== 1'b1) begin nerr++; $display("FAIL starve_stall_c4: got %0h required 1", stall_req); end
      nchecks++; if (md_ready !== 1'b1) begin nerr++; $display("FAIL starve_ready_c4: got %0h required 1", md_ready); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd9 || busW !== 32'hBEEF) begin nerr++; $display("FAIL starve_md_write_c5: got %0h/%0h/%0h required 1/9/beef", RegWr, Rw, busW); end
      @(negedge clk);
      drive(1'b1, 5'd4, 32'hAAAA, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
      #1;
      nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL starve_stall_c5: got %0h required 0", stall_req); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd4 || busW !== 32'hAAAA) begin nerr++; $display("FAIL starve_wb_write_c6: got %0h/%0h/%0h required 1/4/aaaa", RegWr, Rw, busW); end
      @(negedge clk); idle();
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'd0);
      @(posedge clk); #1;
      nchecks++; if (busy_mask !== 32'h0000_1000) begin nerr++; $display("FAIL sb_set12: got %0h required 1000", busy_mask); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
      @(posedge clk); #1;
      nchecks++; if (busy_mask !== 32'h0000_1000) begin nerr++; $display("FAIL sb_issue_r0: got %0h required 1000", busy_mask); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b1, 5'd12, 32'h5555);
      #1;
      nchecks++; if (md_ready !== 1'b1) begin nerr++; $display("FAIL sb_xfer_ready: got %0h required 1", md_ready); end
      @(posedge clk); #1;
      nchecks++; if (busy_mask !== 32'h0000_1000) begin nerr++; $display("FAIL sb_set_wins: got %0h required 1000", busy_mask); end
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd12 || busW !== 32'h5555) begin nerr++; $display("FAIL sb_xfer_write: got %0h/%0h/%0h required 1/c/5555", RegWr, Rw, busW); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd12, 32'h6666);
      @(posedge clk); #1;
      nchecks++; if (busy_mask !== 32'd0) begin nerr++; $display("FAIL sb_clear12: got %0h required 0", busy_mask); end
      @(negedge clk); idle();
   endtask

   task automatic test_reg0();
      @(negedge clk);
      drive(1'b1, 5'd0, 32'h7777, 1'b0, 5'd0, 1'b1, 5'd6, 32'h8888);
      #1;
      nchecks++; if (md_ready !== 1'b0) begin nerr++; $display("FAIL r0_wb_mdready: got %0h required 0", md_ready); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b0) begin nerr++; $display("FAIL r0_wb_regwr: got %0h required 0", RegWr); end
      nchecks++; if (Rw !== 5'd12 || busW !== 32'h6666) begin nerr++; $display("FAIL r0_hold: got %0h/%0h required c/6666", Rw, busW); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h8888);
      #1;
      nchecks++; if (md_ready !== 1'b1) begin nerr++; $display("FAIL r0_md_ready: got %0h required 1", md_ready); end
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b1 || Rw !== 5'd6 || busW !== 32'h8888) begin nerr++; $display("FAIL r0_md_write: got %0h/%0h/%0h required 1/6/8888", RegWr, Rw, busW); end
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h9999);
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b0 || busW !== 32'h8888 || busy_mask[0] !== 1'b0) begin nerr++; $display("FAIL r0_md_dest0: got %0h/%0h/%0h required 0/8888/0", RegWr, busW, busy_mask[0]); end
      @(negedge clk); idle();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 5'd4, 32'hCAFE, (c == 0), 5'd20, 1'b1, 5'd9, 32'hBEEF);
         @(posedge clk);
      end
      #1;
      nchecks++; if (stall_req !== 1'b1 || RegWr !== 1'b1 || busy_mask !== 32'h0010_0000) begin nerr++; $display("FAIL rstmid_pre: got stall=%0h regwr=%0h busy=%0h required 1/1/100000", stall_req, RegWr, busy_mask); end
      #1 rst_n = 1'b0;
      #1;
      nchecks++; if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0) begin nerr++; $display("FAIL rstmid_write: got %0h/%0h/%0h required 0/0/0", RegWr, Rw, busW); end
      nchecks++; if (busy_mask !== 32'd0) begin nerr++; $display("FAIL rstmid_busy: got %0h required 0", busy_mask); end
      nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL rstmid_stall: got %0h required 0", stall_req); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(posedge clk); #1;
      nchecks++; if (RegWr !== 1'b0 || busy_mask !== 32'd0) begin nerr++; $display("FAIL rstmid_after: got %0h/%0h required 0/0", RegWr, busy_mask); end
   endtask

   task automatic test_random();
      bit rdy, stl;
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         wb_valid    = ($urandom_range(0, 99) < 60);
         wb_rw       = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wb_data     = $urandom;
         md_issue    = ($urandom_range(0, 99) < 30);
         md_issue_rw = 5'($urandom_range(0, 31));
         if (md_valid && !m_last_md_g) begin
            // Result still pending: hold it, with a rare illegal withdrawal.
            if ($urandom_range(0, 99) < 3) md_valid = 1'b0;
         end else begin
            md_valid = ($urandom_range(0, 99) < 55);
            md_rw    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            md_data  = $urandom;
         end
         #1;
         model_eval(rdy, stl);
         nchecks++; if (md_ready !== rdy) begin nerr++; $display("FAIL rand_mdready[%0d]: got %0h required %0h", n, md_ready, rdy); end
         nchecks++; if (stall_req !== stl) begin nerr++; $display("FAIL rand_stall[%0d]: got %0h required %0h", n, stall_req, stl); end
         model_commit(rdy, stl);
         @(posedge clk); #1;
         nchecks++; if (RegWr !== m_regwr) begin nerr++; $display("FAIL rand_regwr[%0d]: got %0h required %0h", n, RegWr, m_regwr); end
         nchecks++; if (Rw !== m_rw) begin nerr++; $display("FAIL rand_rw[%0d]: got %0h required %0h", n, Rw, m_rw); end
         nchecks++; if (busW !== m_busw) begin nerr++; $display("FAIL rand_busw[%0d]: got %0h required %0h", n, busW, m_busw); end
         nchecks++; if (busy_mask !== model_mask()) begin nerr++; $display("FAIL rand_busy[%0d]: got %0h required %0h", n, busy_mask, model_mask()); end
      end
      @(negedge clk); idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b1;
      #1;
      test_reset();
      test_wb_only();
      test_simultaneous();
      test_starvation();
      test_scoreboard();
      test_reg0();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/regwr_arbiter.md
# regwr_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit. It tracks destination registers with an outstanding multiply/divide result in a busy scoreboard, used by hazard detection. It forces the pipeline to stall when the multiply/divide result has waited too long. It sits between writeback/mul-div and the register file write inputs (RegWr, Rw, busW).

## Interface

- WIDTH, 32: data width of busW.
- STARVE_LIMIT, 4: cycles md may wait refused before a forced grant; range 1–15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback write request, high-priority requester.
- wb_rw  in  5  writeback destination register.
- wb_data  in  WIDTH  writeback data.
- md_issue  in  1  mul/div instruction issued this cycle.
- md_issue_rw  in  5  destination of the issued mul/div.
- md_valid  in  1  mul/div result available.
- md_rw  in  5  mul/div result destination.
- md_data  in  WIDTH  mul/div result data.
- md_ready  out  1  mul/div result accepted this cycle when md_valid&&md_ready.
- stall_req  out  1  pipeline must freeze; writeback holds wb_valid/wb_rw/wb_data stable.
- RegWr  out  1  register file write enable, registered.
- Rw  out  5  register file write address, registered.
- busW  out  WIDTH  register file write data, registered.
- busy_mask  out  32  bit i set means register i awaits a mul/div result.

## Operation

- States: PRI_WB (reset) and FORCE_MD.
- PRI_WB:
  - If wb_valid, grant wb; md_ready=0.
  - Else md_ready=1, and md is granted if md_valid.
- FORCE_MD:
  - md_ready=1 and stall_req=1; wb is never granted.
  - A wb request present in this state is not lost: the pipeline re-presents it while stalled.
- md_ready is combinational: (state==FORCE_MD) || !wb_valid.
- stall_req is combinational: (state==FORCE_MD).
- wait_cnt (4 bits, reset 0):
  - Increments each cycle md_valid && !md_ready.
  - Clears on an md transfer, or whenever md_valid=0.
- Transitions:
  - PRI_WB→FORCE_MD when wait_cnt==STARVE_LIMIT-1 and md is refused this cycle.
  - FORCE_MD→PRI_WB on an md transfer.
  - FORCE_MD with md_valid=0 (result withdrawn, illegal) → PRI_WB and wait_cnt=0.
- Write command:
  - A granted request with destination ≠0 loads Rw/busW and sets RegWr=1 next cycle.
  - No grant sets RegWr=0 next cycle; Rw/busW hold.
- Register 0:
  - A grant with destination 0 completes its handshake but yields RegWr=0.
  - busy bit 0 is never set.
- Scoreboard:
  - md_issue sets bit md_issue_rw.
  - An md transfer clears bit md_rw.
  - Same-cycle issue and transfer to the same register: set wins.
  - Issue to an already-busy register: the bit stays set.
- Reset (async, any state): state=PRI_WB, wait_cnt=0, RegWr=0, Rw=0, busW=0, busy_mask=0. md_ready and stall_req then follow their equations; stall_req=0.

## Timing

- Grant in cycle N: RegWr/Rw/busW valid throughout cycle N+1; the register file captures at the falling edge within N+1.
- Back-to-back grants produce one write per cycle with no bubble.
- busy_mask is registered: set/clear visible cycle N+1 after issue/transfer in cycle N.
- Worst-case md wait from first refusal is STARVE_LIMIT cycles:
  - STARVE_LIMIT refused cycles in PRI_WB.
  - Then forced grant in the first FORCE_MD cycle.
- stall_req lasts exactly one cycle per forced grant.
- Reset asserted mid-operation: a pending write command is dropped (RegWr=0 immediately). In-flight mul/div results are not tracked after reset.

## Test plan

- Reset mid-operation: assert rst_n=0 mid-cycle with RegWr=1 → RegWr, Rw, busW, busy_mask all 0 asynchronously; state PRI_WB.
- Writeback only: wb_valid=1, wb_rw=5, wb_data=0x1234 in cycle N → cycle N+1 shows RegWr=1, Rw=5, busW=0x1234; md_ready=0 in N.
- Simultaneous requests, no contention history: wb (rw=3) and md (rw=7) valid in N → wb written in N+1; md transferred in N+1, written in N+2; stall_req stays 0.
- Starvation with STARVE_LIMIT=4: wb_valid=1 continuously while md_valid=1 (rw=9, data=0xBEEF):
  - md refused cycles 0–3.
  - Cycle 4: stall_req=1, md_ready=1.
  - Cycle 5: RegWr=1, Rw=9, busW=0xBEEF, stall_req=0.
  - The held wb request is written in cycle 6.
- Scoreboard:
  - md_issue with rw=12 → busy_mask[12]=1 next cycle.
  - md_issue with rw=0 → bit 0 stays 0.
  - md transfer rw=12 with same-cycle md_issue rw=12 → bit 12 remains 1.
  - A later md transfer rw=12 → bit 12 clears.
- Register 0 write: wb_valid=1, wb_rw=0 → RegWr=0 next cycle; md granted only in cycles with wb_valid=0.
